// File: rtl/multi_entry_reservation_station_pkg.sv
// Shared types for the multi-entry reservation station.
//   - Sizing constants (operand width, entry count, CDB port count).
//   - Producer tags, decoded op, operand register and per-entry record.
//   - snoop(): resolves a virtual operand against the CDB ports.
package multi_entry_reservation_station_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;
    localparam int NUM_CDB    = 1;
    localparam int SLOT_W     = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_LSU, FU_BR} e_functional_unit;

    // Tag of a produced value: owning station plus its slot in that station.
    typedef struct packed {
        e_functional_unit  unit;
        logic [SLOT_W-1:0] slot;
    } rs_tag_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic       has_rs1;
        logic       has_rs2;
    } op_t;

    // Operand: either a concrete value or a pending producer tag.
    typedef struct packed {
        logic                  is_virtual;
        rs_tag_t               rs_id;
        logic [DATA_WIDTH-1:0] value;
    } register_t;

    typedef enum logic [1:0] {RS_FREE, RS_WAITING, RS_READY, RS_EXECUTING} e_rs_entry_state;

    typedef struct packed {
        e_rs_entry_state state;
        op_t             op;
        register_t       j;
        register_t       k;
    } rs_entry_t;

    // Capture a broadcast result into a still-virtual operand on tag match.
    function automatic register_t snoop(
        input register_t                             r,
        input logic [NUM_CDB-1:0]                    en,
        input rs_tag_t [NUM_CDB-1:0]                 tag,
        input logic [NUM_CDB-1:0][DATA_WIDTH-1:0]    data
    );
        register_t o;
        o = r;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (r.is_virtual && en[p] && (tag[p] == r.rs_id)) begin
                o.value      = data[p];
                o.is_virtual = 1'b0;
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/multi_entry_reservation_station_age_matrix.sv
// Age matrix: tracks allocation order between entries and picks the oldest
// requester.
//   clk, rst_n : clock, async active-low reset
//   alloc_i    : one-hot slot allocated this cycle
//   free_i     : slots freed this cycle (all ones on flush)
//   req_i      : slots requesting selection
//   gnt_o      : one-hot oldest requester (zero when req_i is zero)
module multi_entry_reservation_station_age_matrix #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] alloc_i,
    input  logic [N-1:0] free_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    // age_q[i][j] set means entry i is older than entry j.
    logic [N-1:0][N-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                // A newcomer is older than nobody; everyone else is older than it.
                // Setting bits for free rows is harmless: a row is cleared on alloc.
                if (alloc_i[i]) age_d[i][j] = 1'b0;
                if (alloc_i[j] && (i != j)) age_d[i][j] = 1'b1;
                if (free_i[i] || free_i[j]) age_d[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end

    // Granted when no other requester is older.
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = req_i[i];
            for (int j = 0; j < N; j++) begin
                if ((j != i) && req_i[j] && age_q[j][i]) gnt_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_entry_reservation_station.sv
// Reservation station for one functional unit: allocates decoded ops into
// free slots, wakes virtual operands from the CDB, and offers the oldest
// ready entry to the unit. Slots free on retirement; flush clears all.
//   clk, rst_n                 : clock, async active-low reset
//   issue_valid_i/ready_o      : allocation handshake (ready = a slot is free)
//   issue_op_i, read1/2_value_i: op and operands (value or producer tag)
//   issue_tag_o                : {RS_ID, slot} given to this cycle's alloc
//   bcast_en/tag/data_i        : CDB snoop ports
//   disp_valid_o/ready_i       : dispatch handshake with the unit
//   disp_op/op1/op2/tag_o      : offered entry
//   retire_i, retire_tag_i     : frees an executing slot
//   flush_i                    : clears every entry next cycle
//   count_o                    : occupied entries
module multi_entry_reservation_station
    import multi_entry_reservation_station_pkg::*;
#(
    parameter e_functional_unit RS_ID = FU_ALU
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               issue_valid_i,
    output logic                               issue_ready_o,
    input  op_t                                issue_op_i,
    input  register_t                          read1_value_i,
    input  register_t                          read2_value_i,
    output rs_tag_t                            issue_tag_o,
    input  logic [NUM_CDB-1:0]                 bcast_en_i,
    input  rs_tag_t [NUM_CDB-1:0]              bcast_tag_i,
    input  logic [NUM_CDB-1:0][DATA_WIDTH-1:0] bcast_data_i,
    output logic                               disp_valid_o,
    input  logic                               disp_ready_i,
    output op_t                                disp_op_o,
    output logic [DATA_WIDTH-1:0]              disp_op1_o,
    output logic [DATA_WIDTH-1:0]              disp_op2_o,
    output rs_tag_t                            disp_tag_o,
    input  logic                               retire_i,
    input  rs_tag_t                            retire_tag_i,
    input  logic                               flush_i,
    output logic [CNT_W-1:0]                   count_o
);

    rs_entry_t [DEPTH-1:0] ent_q, ent_d;
    register_t [DEPTH-1:0] wj, wk;
    register_t             nj, nk;

    logic [DEPTH-1:0]  free_vec, ready_vec, alloc_oh, retire_hit, free_oh, gnt;
    logic [SLOT_W-1:0] alloc_slot;
    logic              do_alloc, do_disp, bcast_dup;

    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i]  = (ent_q[i].state == RS_FREE);
            ready_vec[i] = (ent_q[i].state == RS_READY);
            if (!free_vec[i]) count_o = count_o + CNT_W'(1);
        end
    end

    // Lowest-index free slot.
    always_comb begin
        alloc_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_slot = SLOT_W'(i);
        end
    end

    assign issue_ready_o = |free_vec;
    assign issue_tag_o   = '{unit: RS_ID, slot: alloc_slot};
    assign do_alloc      = issue_valid_i & issue_ready_o & ~flush_i;
    assign disp_valid_o  = |ready_vec;
    assign do_disp       = disp_valid_o & disp_ready_i & ~flush_i;

    always_comb begin
        alloc_oh   = '0;
        retire_hit = '0;
        if (do_alloc) alloc_oh[alloc_slot] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            retire_hit[i] = retire_i && !flush_i && (retire_tag_i.unit == RS_ID) &&
                            (retire_tag_i.slot == SLOT_W'(i)) &&
                            (ent_q[i].state == RS_EXECUTING);
        end
        free_oh = flush_i ? '1 : retire_hit;
    end

    multi_entry_reservation_station_age_matrix #(.N(DEPTH)) u_age (
        .clk     (clk),
        .rst_n   (rst_n),
        .alloc_i (alloc_oh),
        .free_i  (free_oh),
        .req_i   (ready_vec),
        .gnt_o   (gnt)
    );

    // Incoming operands: absent sources count as resolved, then same-cycle bypass.
    always_comb begin
        nj = read1_value_i;
        nk = read2_value_i;
        if (!issue_op_i.has_rs1) nj.is_virtual = 1'b0;
        if (!issue_op_i.has_rs2) nk.is_virtual = 1'b0;
        nj = snoop(nj, bcast_en_i, bcast_tag_i, bcast_data_i);
        nk = snoop(nk, bcast_en_i, bcast_tag_i, bcast_data_i);
    end

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            wj[i] = snoop(ent_q[i].j, bcast_en_i, bcast_tag_i, bcast_data_i);
            wk[i] = snoop(ent_q[i].k, bcast_en_i, bcast_tag_i, bcast_data_i);
            case (ent_q[i].state)
                RS_FREE: begin
                    if (alloc_oh[i]) begin
                        ent_d[i].op    = issue_op_i;
                        ent_d[i].j     = nj;
                        ent_d[i].k     = nk;
                        ent_d[i].state = (nj.is_virtual || nk.is_virtual) ? RS_WAITING : RS_READY;
                    end
                end
                RS_WAITING: begin
                    ent_d[i].j = wj[i];
                    ent_d[i].k = wk[i];
                    if (!wj[i].is_virtual && !wk[i].is_virtual) ent_d[i].state = RS_READY;
                end
                RS_READY: begin
                    if (do_disp && gnt[i]) ent_d[i].state = RS_EXECUTING;
                end
                RS_EXECUTING: begin
                    if (retire_hit[i]) ent_d[i].state = RS_FREE;
                end
                default: ent_d[i].state = RS_FREE;
            endcase
            if (flush_i) ent_d[i].state = RS_FREE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ent_q <= '0;
        else        ent_q <= ent_d;
    end

    // Dispatch mux; grant is one-hot among ready entries.
    always_comb begin
        disp_op_o  = '0;
        disp_op1_o = '0;
        disp_op2_o = '0;
        disp_tag_o = '{unit: RS_ID, slot: '0};
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
                disp_op_o       = ent_q[i].op;
                disp_op1_o      = ent_q[i].j.value;
                disp_op2_o      = ent_q[i].k.value;
                disp_tag_o.slot = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        bcast_dup = 1'b0;
        for (int p = 0; p < NUM_CDB; p++) begin
            for (int q = p + 1; q < NUM_CDB; q++) begin
                if (bcast_en_i[p] && bcast_en_i[q] && (bcast_tag_i[p] == bcast_tag_i[q]))
                    bcast_dup = 1'b1;
            end
        end
    end

    a_no_dup_bcast: assert property (@(posedge clk) disable iff (!rst_n) !bcast_dup);

    a_retire_exec: assert property (@(posedge clk) disable iff (!rst_n)
        (retire_i && !flush_i) |-> ((retire_tag_i.unit == RS_ID) &&
                                    (ent_q[retire_tag_i.slot].state == RS_EXECUTING)));

endmodule

// File: tb/tb_multi_entry_reservation_station.sv
module tb_multi_entry_reservation_station;
    import multi_entry_reservation_station_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst_n = 1'b0;
    logic                               issue_valid_i;
    logic                               issue_ready_o;
    op_t                                issue_op_i;
    register_t                          read1_value_i, read2_value_i;
    rs_tag_t                            issue_tag_o;
    logic [NUM_CDB-1:0]                 bcast_en_i;
    rs_tag_t [NUM_CDB-1:0]              bcast_tag_i;
    logic [NUM_CDB-1:0][DATA_WIDTH-1:0] bcast_data_i;
    logic                               disp_valid_o, disp_ready_i;
    op_t                                disp_op_o;
    logic [DATA_WIDTH-1:0]              disp_op1_o, disp_op2_o;
    rs_tag_t                            disp_tag_o;
    logic                               retire_i;
    rs_tag_t                            retire_tag_i;
    logic                               flush_i;
    logic [CNT_W-1:0]                   count_o;

    multi_entry_reservation_station #(.RS_ID(FU_ALU)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_op_i(issue_op_i), .read1_value_i(read1_value_i), .read2_value_i(read2_value_i),
        .issue_tag_o(issue_tag_o),
        .bcast_en_i(bcast_en_i), .bcast_tag_i(bcast_tag_i), .bcast_data_i(bcast_data_i),
        .disp_valid_o(disp_valid_o), .disp_ready_i(disp_ready_i),
        .disp_op_o(disp_op_o), .disp_op1_o(disp_op1_o), .disp_op2_o(disp_op2_o),
        .disp_tag_o(disp_tag_o),
        .retire_i(retire_i), .retire_tag_i(retire_tag_i), .flush_i(flush_i),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        rs_tag_t     tag;
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic        chk_b;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    localparam op_t ADD = '{opcode: 4'h1, has_rs1: 1'b1, has_rs2: 1'b1};
    localparam op_t SUB = '{opcode: 4'h2, has_rs1: 1'b1, has_rs2: 1'b1};
    localparam op_t LUI = '{opcode: 4'h3, has_rs1: 1'b1, has_rs2: 1'b0};

    function automatic rs_tag_t T(input e_functional_unit u, input int s);
        return '{unit: u, slot: SLOT_W'(s)};
    endfunction
    function automatic register_t conc(input logic [31:0] v);
        return '{is_virtual: 1'b0, rs_id: '0, value: v};
    endfunction
    function automatic register_t virt(input rs_tag_t t);
        return '{is_virtual: 1'b1, rs_id: t, value: '0};
    endfunction

    // Dispatch monitor: every accepted offer is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !flush_i && disp_valid_o && disp_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL disp_unexpected tag=%h op1=%h op2=%h", disp_tag_o, disp_op1_o, disp_op2_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (disp_tag_o !== mon_e.tag || disp_op_o !== mon_e.op || disp_op1_o !== mon_e.a ||
                    (mon_e.chk_b && disp_op2_o !== mon_e.b)) begin
                    errors++;
                    $display("FAIL disp got tag=%h op=%h op1=%h op2=%h want tag=%h op=%h op1=%h op2=%h",
                             disp_tag_o, disp_op_o, disp_op1_o, disp_op2_o,
                             mon_e.tag, mon_e.op, mon_e.a, mon_e.b);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic clr();
        issue_valid_i = 1'b0;
        bcast_en_i    = '0;
        disp_ready_i  = 1'b0;
        retire_i      = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic alloc(input op_t op, input register_t a, input register_t b);
        issue_valid_i = 1'b1;
        issue_op_i    = op;
        read1_value_i = a;
        read2_value_i = b;
    endtask

    task automatic bc(input rs_tag_t t, input logic [31:0] d);
        bcast_en_i      = 1'b1;
        bcast_tag_i[0]  = t;
        bcast_data_i[0] = d;
    endtask

    task automatic ret(input int s);
        retire_i     = 1'b1;
        retire_tag_i = T(FU_ALU, s);
    endtask

    task automatic disp(input int s, input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic cb);
        exp_t e;
        disp_ready_i = 1'b1;
        e = '{tag: T(FU_ALU, s), op: op, a: a, b: b, chk_b: cb};
        exp_q.push_back(e);
    endtask

    initial begin
        clr();
        issue_op_i    = '0;
        read1_value_i = '0;
        read2_value_i = '0;
        bcast_tag_i   = '0;
        bcast_data_i  = '0;
        retire_tag_i  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        mid();
        chk("rst_ready", 64'(issue_ready_o), 64'(1));
        chk("rst_dv", 64'(disp_valid_o), 64'(0));
        chk("rst_cnt", 64'(count_o), 64'(0));
        rst_n = 1'b1;
        nxt();

        // 1: concrete ADD, dispatch next cycle, retire
        alloc(ADD, conc(5), conc(7)); mid();
        chk("t1_tag", 64'(issue_tag_o), 64'(T(FU_ALU, 0)));
        nxt();
        disp(0, ADD, 5, 7, 1'b1); mid();
        chk("t1_dv", 64'(disp_valid_o), 64'(1));
        chk("t1_cnt1", 64'(count_o), 64'(1));
        nxt();
        ret(0); mid();
        chk("t1_dv_exec", 64'(disp_valid_o), 64'(0));
        nxt();
        mid();
        chk("t1_cnt0", 64'(count_o), 64'(0));
        nxt();

        // 2: virtual op1 woken two cycles after alloc
        alloc(ADD, virt(T(FU_ALU, 2)), conc(3)); mid(); nxt();
        mid(); chk("t2_wait1", 64'(disp_valid_o), 64'(0)); nxt();
        bc(T(FU_ALU, 2), 32'hDEAD); mid(); chk("t2_wait2", 64'(disp_valid_o), 64'(0)); nxt();
        disp(0, ADD, 32'hDEAD, 3, 1'b1); mid(); chk("t2_dv", 64'(disp_valid_o), 64'(1)); nxt();
        ret(0); mid(); nxt();

        // 3: bypass at alloc
        alloc(ADD, conc(9), virt(T(FU_MUL, 1))); bc(T(FU_MUL, 1), 32'h1234); mid(); nxt();
        disp(0, ADD, 9, 32'h1234, 1'b1); mid(); chk("t3_dv", 64'(disp_valid_o), 64'(1)); nxt();
        ret(0); mid(); nxt();
        // op without rs2: virtual second operand counts as resolved
        alloc(LUI, conc(42), virt(T(FU_LSU, 3))); mid(); nxt();
        disp(0, LUI, 42, 0, 1'b0); mid(); chk("t3_nors2_dv", 64'(disp_valid_o), 64'(1)); nxt();
        ret(0); mid(); nxt();

        // 4: fill, 5th ignored, retire slot1 and reuse it
        for (int s = 0; s < 4; s++) begin
            alloc(ADD, conc(32'(10 + s)), conc(32'(20 + s))); mid();
            chk("t4_tag", 64'(issue_tag_o), 64'(T(FU_ALU, s)));
            nxt();
        end
        alloc(SUB, conc(99), conc(98)); mid();
        chk("t4_full_ready", 64'(issue_ready_o), 64'(0));
        chk("t4_full_cnt", 64'(count_o), 64'(4));
        nxt();
        disp(0, ADD, 10, 20, 1'b1); mid(); chk("t4_cnt_after5th", 64'(count_o), 64'(4)); nxt();
        disp(1, ADD, 11, 21, 1'b1); mid(); nxt();
        ret(1); alloc(SUB, conc(1), conc(2)); mid();
        chk("t4_ret_same_cycle_ready", 64'(issue_ready_o), 64'(0));
        nxt();
        alloc(SUB, conc(1), conc(2)); mid();
        chk("t4_ready_after_ret", 64'(issue_ready_o), 64'(1));
        chk("t4_reuse_tag", 64'(issue_tag_o), 64'(T(FU_ALU, 1)));
        chk("t4_cnt3", 64'(count_o), 64'(3));
        nxt();
        mid(); chk("t4_cnt4", 64'(count_o), 64'(4)); nxt();
        flush_i = 1'b1; mid(); nxt();
        mid(); chk("t4_flush_cnt", 64'(count_o), 64'(0)); nxt();

        // 5: oldest first by allocation order
        alloc(ADD, conc(1), conc(2)); mid(); nxt();
        alloc(SUB, conc(3), conc(4)); mid(); chk("t5_tag1", 64'(issue_tag_o), 64'(T(FU_ALU, 1))); nxt();
        disp(0, ADD, 1, 2, 1'b1); mid(); nxt();
        disp(1, SUB, 3, 4, 1'b1); mid(); nxt();
        ret(0); mid(); nxt();
        ret(1); mid(); nxt();
        // age wins over slot index: slot1 older than reused slot0
        alloc(ADD, conc(1), conc(2)); mid(); nxt();
        alloc(SUB, virt(T(FU_MUL, 0)), conc(4)); disp(0, ADD, 1, 2, 1'b1); mid(); nxt();
        ret(0); mid(); nxt();
        alloc(ADD, conc(5), conc(6)); bc(T(FU_MUL, 0), 32'h77); mid();
        chk("t5b_reuse0", 64'(issue_tag_o), 64'(T(FU_ALU, 0)));
        nxt();
        disp(1, SUB, 32'h77, 4, 1'b1); mid();
        chk("t5b_oldest", 64'(disp_tag_o), 64'(T(FU_ALU, 1)));
        nxt();
        disp(0, ADD, 5, 6, 1'b1); mid(); nxt();
        ret(1); mid(); nxt();
        ret(0); mid(); nxt();
        mid(); chk("t5_cnt0", 64'(count_o), 64'(0)); nxt();

        // 6: flush with 3 occupied plus concurrent alloc and broadcast
        alloc(ADD, conc(1), conc(1)); mid(); nxt();
        alloc(ADD, conc(2), conc(2)); mid(); nxt();
        alloc(ADD, virt(T(FU_MUL, 2)), conc(3)); mid(); nxt();
        flush_i = 1'b1; alloc(SUB, conc(4), conc(4)); bc(T(FU_MUL, 2), 32'h5); mid(); nxt();
        mid();
        chk("t6_flush_cnt", 64'(count_o), 64'(0));
        chk("t6_flush_dv", 64'(disp_valid_o), 64'(0));
        chk("t6_flush_ready", 64'(issue_ready_o), 64'(1));
        nxt();
        alloc(ADD, conc(7), conc(8)); mid(); chk("t6_tag0", 64'(issue_tag_o), 64'(T(FU_ALU, 0))); nxt();
        alloc(ADD, conc(7), conc(8)); mid(); nxt();
        mid(); chk("t6_cnt2", 64'(count_o), 64'(2));
        // asynchronous reset between clock edges
        rst_n = 1'b0;
        #1;
        chk("t6_arst_cnt", 64'(count_o), 64'(0));
        chk("t6_arst_dv", 64'(disp_valid_o), 64'(0));
        chk("t6_arst_ready", 64'(issue_ready_o), 64'(1));
        mid();
        rst_n = 1'b1;
        nxt();
        alloc(ADD, conc(1), conc(2)); mid();
        chk("t6_post_rst_tag", 64'(issue_tag_o), 64'(T(FU_ALU, 0)));
        nxt();

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
